alarm_controller: RTL and testbench



---
 rtl/alarm_pkg.sv | 13 +
 rtl/alarm_sensor_mask.sv | 18 +
 rtl/alarm_controller.sv | 90 +++++++++
 tb/tb_alarm_controller.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and default constants for the intrusion-alarm controller.
package alarm_pkg;

  localparam int unsigned NUM_SEN_DEF  = 4;
  localparam logic [3:0]  SEN_MASK_DEF = 4'b1111;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    ALARM    = 2'd2
  } state_e;

endpackage

// File: rtl/alarm_sensor_mask.sv
// Qualifies raw sensor levels with the per-sensor enable mask.
module alarm_sensor_mask
  import alarm_pkg::*;
#(
  parameter int unsigned          NUM_SEN  = NUM_SEN_DEF,
  parameter logic [NUM_SEN-1:0]   SEN_MASK = SEN_MASK_DEF
) (
  input  logic [NUM_SEN-1:0] sen,
  output logic [NUM_SEN-1:0] act_c,
  output logic               any_c
);

  always_comb begin
    act_c = sen & SEN_MASK;
    any_c = |act_c;
  end

endmodule

// File: rtl/alarm_controller.sv
// Arm/disarm alarm FSM with registered Moore outputs; latching or follow mode
// selected by LATCH.
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int unsigned          NUM_SEN  = NUM_SEN_DEF,
  parameter logic [NUM_SEN-1:0]   SEN_MASK = SEN_MASK_DEF,
  parameter bit                   LATCH    = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SEN-1:0] sen,
  input  logic               en,
  output logic               alarm_out,
  output logic               armed,
  output logic [NUM_SEN-1:0] trip_sen
);

  logic [NUM_SEN-1:0] act_c;
  logic               any_c;
  state_e             state;

  alarm_sensor_mask #(
    .NUM_SEN  (NUM_SEN),
    .SEN_MASK (SEN_MASK)
  ) u_mask (
    .sen   (sen),
    .act_c (act_c),
    .any_c (any_c)
  );

  // State and outputs update together so the outputs always decode the new state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= DISARMED;
      alarm_out <= 1'b0;
      armed     <= 1'b0;
      trip_sen  <= '0;
    end else begin
      case (state)
        DISARMED: begin
          if (en) begin
            state     <= ARMED;
            alarm_out <= 1'b0;
            armed     <= 1'b1;
            trip_sen  <= '0;
          end
        end
        ARMED: begin
          if (!en) begin
            state     <= DISARMED;
            alarm_out <= 1'b0;
            armed     <= 1'b0;
            trip_sen  <= '0;
          end else if (any_c) begin
            state     <= ALARM;
            alarm_out <= 1'b1;
            armed     <= 1'b1;
            trip_sen  <= act_c;
          end
        end
        ALARM: begin
          // Disarm wins over any sensor activity.
          if (!en) begin
            state     <= DISARMED;
            alarm_out <= 1'b0;
            armed     <= 1'b0;
            trip_sen  <= '0;
          end else if (LATCH) begin
            trip_sen  <= trip_sen | act_c;
          end else if (!any_c) begin
            state     <= ARMED;
            alarm_out <= 1'b0;
            armed     <= 1'b1;
            trip_sen  <= '0;
          end else begin
            trip_sen  <= act_c;
          end
        end
        default: begin
          state     <= DISARMED;
          alarm_out <= 1'b0;
          armed     <= 1'b0;
          trip_sen  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: three configurations (latching, follow, masked)
// driven in parallel and compared against a rule-level reference model.
module tb_alarm_controller;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] sen;

  logic       alm  [3];
  logic       arm  [3];
  logic [3:0] trip [3];

  int checks = 0;
  int errors = 0;
  string phase = "init";

  // Reference model: per configuration, plain flags for "armed" and "sounding".
  localparam logic [3:0] MASKS   [3] = '{4'b1111, 4'b1111, 4'b1110};
  localparam bit         LATCHES [3] = '{1'b1, 1'b0, 1'b1};
  bit         m_arm  [3];
  bit         m_alm  [3];
  logic [3:0] m_trip [3];

  alarm_controller #(.NUM_SEN(4), .SEN_MASK(4'b1111), .LATCH(1'b1)) u_latch (
    .clk(clk), .rst(rst), .sen(sen), .en(en),
    .alarm_out(alm[0]), .armed(arm[0]), .trip_sen(trip[0])
  );

  alarm_controller #(.NUM_SEN(4), .SEN_MASK(4'b1111), .LATCH(1'b0)) u_follow (
    .clk(clk), .rst(rst), .sen(sen), .en(en),
    .alarm_out(alm[1]), .armed(arm[1]), .trip_sen(trip[1])
  );

  alarm_controller #(.NUM_SEN(4), .SEN_MASK(4'b1110), .LATCH(1'b1)) u_mask (
    .clk(clk), .rst(rst), .sen(sen), .en(en),
    .alarm_out(alm[2]), .armed(arm[2]), .trip_sen(trip[2])
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  task automatic chk(input string tag, input int idx, input logic [3:0] obs,
                     input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s[%0d] observed=%b expected=%b", phase, tag, idx, obs, exp);
    end
  endtask

  function automatic void model_step(input int i, input bit r, input bit e,
                                     input logic [3:0] s);
    logic [3:0] act;
    act = s & MASKS[i];
    if (r || !e) begin
      m_arm[i]  = 1'b0;
      m_alm[i]  = 1'b0;
      m_trip[i] = 4'b0;
    end else if (!m_arm[i]) begin
      m_arm[i] = 1'b1;
    end else if (!m_alm[i]) begin
      if (act != 4'b0) begin
        m_alm[i]  = 1'b1;
        m_trip[i] = act;
      end
    end else if (LATCHES[i]) begin
      m_trip[i] = m_trip[i] | act;
    end else if (act == 4'b0) begin
      m_alm[i]  = 1'b0;
      m_trip[i] = 4'b0;
    end else begin
      m_trip[i] = act;
    end
  endfunction

  // Apply inputs, clock once, update the model, then compare just after the edge.
  task automatic tick(input bit r, input bit e, input logic [3:0] s);
    rst = r;
    en  = e;
    sen = s;
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i, r, e, s);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("alarm_out", i, {3'b0, alm[i]}, {3'b0, m_alm[i]});
      chk("armed",     i, {3'b0, arm[i]}, {3'b0, m_arm[i]});
      chk("trip_sen",  i, trip[i], m_trip[i]);
      chk("no_x", i, {3'b0, $isunknown({alm[i], arm[i], trip[i]})}, 4'b0);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_arm[i]  = 1'b0;
      m_alm[i]  = 1'b0;
      m_trip[i] = 4'b0;
    end
    rst = 1'b1;
    en  = 1'b1;
    sen = 4'hF;

    phase = "reset";
    tick(1'b1, 1'b1, 4'hF);
    tick(1'b1, 1'b1, 4'hF);
    chk("rst_alarm", 0, {3'b0, alm[0]}, 4'b0);
    chk("rst_trip",  0, trip[0], 4'b0);

    phase = "arm_trip";
    tick(1'b0, 1'b1, 4'b0000);
    tick(1'b0, 1'b1, 4'b0000);
    chk("armed_lit", 0, {3'b0, arm[0]}, 4'b0001);
    tick(1'b0, 1'b1, 4'b0100);
    chk("trip_lit", 0, trip[0], 4'b0100);
    chk("alarm_lit", 0, {3'b0, alm[0]}, 4'b0001);

    phase = "latch";
    for (int k = 0; k < 5; k++) tick(1'b0, 1'b1, 4'b0000);
    chk("hold_lit", 0, {3'b0, alm[0]}, 4'b0001);
    tick(1'b0, 1'b1, 4'b0001);
    chk("join_lit", 0, trip[0], 4'b0101);
    tick(1'b0, 1'b0, 4'b0001);
    chk("disarm_lit", 0, {arm[0], alm[0], trip[0][1:0]}, 4'b0000);

    phase = "follow";
    tick(1'b0, 1'b1, 4'b0000);
    tick(1'b0, 1'b1, 4'b0010);
    chk("f_trip_lit", 1, trip[1], 4'b0010);
    tick(1'b0, 1'b1, 4'b0000);
    chk("f_clear_lit", 1, {2'b0, alm[1], arm[1]}, 4'b0001);
    chk("f_trip0_lit", 1, trip[1], 4'b0000);

    phase = "mask";
    tick(1'b0, 1'b0, 4'b0000);
    tick(1'b0, 1'b1, 4'b0000);
    for (int k = 0; k < 10; k++) tick(1'b0, 1'b1, 4'b0001);
    chk("m_quiet_lit", 2, {3'b0, alm[2]}, 4'b0000);
    tick(1'b0, 1'b1, 4'b1000);
    chk("m_trip_lit", 2, {3'b0, alm[2]}, 4'b0001);
    chk("m_tripsen_lit", 2, trip[2], 4'b1000);

    phase = "en_with_sensor";
    tick(1'b0, 1'b0, 4'b0100);
    tick(1'b0, 1'b1, 4'b0100);
    chk("late_arm", 0, {2'b0, arm[0], alm[0]}, 4'b0010);
    tick(1'b0, 1'b1, 4'b0100);
    chk("late_alarm", 0, {3'b0, alm[0]}, 4'b0001);

    // en toggles every 100 time units (25 clocks) while sen counts up per edge.
    phase = "sweep";
    tick(1'b1, 1'b0, 4'b0000);
    for (int c = 0; c < 200; c++) tick(1'b0, ((c / 25) % 2) == 1, 4'(c));

    phase = "random";
    for (int c = 0; c < 600; c++) begin
      tick($urandom_range(0, 59) == 0,
           $urandom_range(0, 9) != 0,
           ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
